// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: FSM states, operation encoding
// and the iteration count helper.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIN} mdu_state_e;

  typedef enum logic {MUL, DIV} mdu_op_e;

  // One result bit per iteration, so the loop runs once per operand bit.
  function automatic int iter_count(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shifted partial remainder vs divisor gives
// the next remainder and one quotient bit.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   part_rem,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem,
  output logic         q_bit
);

  // The remainder entering a step is below the divisor, so the difference fits in W bits.
  assign q_bit    = (part_rem >= {1'b0, divisor});
  assign next_rem = q_bit ? W'(part_rem - {1'b0, divisor}) : part_rem[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier and restoring divider, one bit per clock.
// The divider is built only when MULT_DIV_UNIT_DIV_EN is defined; otherwise div_start reports BF_OUT.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [OPERAND_WIDTH-1:0] Operand1,
  input  logic [OPERAND_WIDTH-1:0] Operand2,
  input  logic                     Signed_Op,
  input  logic                     mult_start,
  input  logic                     div_start,
  output logic [OPERAND_WIDTH-1:0] ALU_OUT,
  output logic [OPERAND_WIDTH-1:0] ALU_OUT2,
  output logic                     mult_div_done,
  output logic                     Busy,
  output logic                     OF_OUT,
  output logic                     DZ_OUT,
  output logic                     BF_OUT
);

  localparam int W     = OPERAND_WIDTH;
  localparam int ITERS = iter_count(OPERAND_WIDTH);
  localparam int CW    = $clog2(ITERS + 1);

  mdu_state_e    state;
  mdu_op_e       op;
  logic [W-1:0]  acc_hi, acc_lo, mag_b;
  logic [CW-1:0] cnt;
  logic          neg_lo, neg_hi, bypass, fin_wait;
  logic          of_p, dz_p, bf_p;

  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    mul_sum;
  logic          sign_diff;

  assign a_mag     = (Signed_Op && Operand1[W-1]) ? -Operand1 : Operand1;
  assign b_mag     = (Signed_Op && Operand2[W-1]) ? -Operand2 : Operand2;
  assign sign_diff = Signed_Op && (Operand1[W-1] ^ Operand2[W-1]);

  // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the running high word.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

`ifdef MULT_DIV_UNIT_DIV_EN
  logic [W-1:0] div_rem;
  logic         div_qbit;

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
  mdu_div_step #(.W(W)) u_div_step (
    .part_rem ({acc_hi, acc_lo[W-1]}),
    .divisor  (mag_b),
    .next_rem (div_rem),
    .q_bit    (div_qbit)
  );
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      op            <= MUL;
      acc_hi        <= '0;
      acc_lo        <= '0;
      mag_b         <= '0;
      cnt           <= '0;
      neg_lo        <= 1'b0;
      neg_hi        <= 1'b0;
      bypass        <= 1'b0;
      fin_wait      <= 1'b0;
      of_p          <= 1'b0;
      dz_p          <= 1'b0;
      bf_p          <= 1'b0;
      ALU_OUT       <= '0;
      ALU_OUT2      <= '0;
      mult_div_done <= 1'b0;
      Busy          <= 1'b0;
      OF_OUT        <= 1'b0;
      DZ_OUT        <= 1'b0;
      BF_OUT        <= 1'b0;
    end else begin
      mult_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            op       <= MUL;
            acc_hi   <= '0;
            acc_lo   <= b_mag;
            mag_b    <= a_mag;
            neg_lo   <= sign_diff;
            bypass   <= 1'b0;
            fin_wait <= 1'b0;
            of_p     <= 1'b0;
            dz_p     <= 1'b0;
            bf_p     <= 1'b0;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= BUSY;
          end else if (div_start) begin
            of_p <= 1'b0;
            dz_p <= 1'b0;
            bf_p <= 1'b0;
            cnt  <= '0;
            Busy <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
            op <= DIV;
            if (Operand2 == '0) begin
              // Divide by zero: results are preloaded and the FIN state waits one extra cycle.
              acc_lo   <= '1;
              acc_hi   <= Operand1;
              bypass   <= 1'b1;
              fin_wait <= 1'b1;
              dz_p     <= 1'b1;
              state    <= FIN;
            end else begin
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              mag_b    <= b_mag;
              neg_lo   <= sign_diff;
              neg_hi   <= Signed_Op && Operand1[W-1];
              bypass   <= 1'b0;
              fin_wait <= 1'b0;
              of_p     <= Signed_Op && (Operand1 == {1'b1, {(W-1){1'b0}}}) && (Operand2 == '1);
              state    <= BUSY;
            end
`else
            op       <= MUL;
            acc_hi   <= '0;
            acc_lo   <= '0;
            bypass   <= 1'b1;
            fin_wait <= 1'b1;
            bf_p     <= 1'b1;
            state    <= FIN;
`endif
          end
        end
        BUSY: begin
          if (op == MUL) begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
          end
`ifdef MULT_DIV_UNIT_DIV_EN
          else begin
            acc_hi <= div_rem;
            acc_lo <= {acc_lo[W-2:0], div_qbit};
          end
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= FIN;
        end
        FIN: begin
          if (fin_wait) begin
            fin_wait <= 1'b0;
          end else begin
            state         <= IDLE;
            Busy          <= 1'b0;
            mult_div_done <= 1'b1;
            OF_OUT        <= of_p;
            DZ_OUT        <= dz_p;
            BF_OUT        <= bf_p;
            if (bypass) begin
              ALU_OUT  <= acc_lo;
              ALU_OUT2 <= acc_hi;
            end else if (op == MUL) begin
              {ALU_OUT2, ALU_OUT} <= neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
            end else begin
              ALU_OUT  <= neg_lo ? -acc_lo : acc_lo;
              ALU_OUT2 <= neg_hi ? -acc_hi : acc_hi;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have ports, in this order:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Operand1  in  OPERAND_WIDTH  multiplicand / dividend.
- Operand2  in  OPERAND_WIDTH  multiplier / divisor.
- Signed_Op  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- mult_start  in  1  multiply request.
- div_start  in  1  divide request.
- ALU_OUT  out  OPERAND_WIDTH  product low word / quotient.
- ALU_OUT2  out  OPERAND_WIDTH  product high word / remainder.
- mult_div_done  out  1  one-cycle completion pulse.
- Busy  out  1  operation in progress.
- OF_OUT  out  1  signed divide overflow.
- DZ_OUT  out  1  divide by zero.
- BF_OUT  out  1  unsupported operation.

Function
REQ-003 SHALL use three states: IDLE, BUSY and FIN.
REQ-004 SHALL sample a start only in IDLE: operands and Signed_Op captured at that edge (edge N), state moves to BUSY.
- Starts asserted while BUSY or FIN are ignored.
REQ-005 SHALL give mult_start priority when mult_start and div_start are both high in IDLE.
REQ-006 SHALL convert signed operands to magnitudes at capture and perform 32 iterations, one per edge (N+1..N+32):
- multiply: shift-add, 2*OPERAND_WIDTH-bit product.
- divide: restoring, one quotient bit per edge.
REQ-007 SHALL move to FIN at edge N+32.
REQ-008 SHALL, at edge N+33 (FIN -> IDLE):
- apply sign correction;
- register the results on ALU_OUT/ALU_OUT2;
- set mult_div_done=1 for exactly one cycle.
REQ-009 SHALL apply these sign rules:
- product negative iff the operand signs differ;
- quotient negative iff the operand signs differ;
- remainder takes the sign of the dividend.
REQ-010 SHALL, on a divide with Operand2==0, skip BUSY and go IDLE->FIN, then complete at edge N+2 with ALU_OUT=all ones, ALU_OUT2=Operand1, DZ_OUT=1.
REQ-011 SHALL, on a signed divide of most-negative / -1, complete with normal latency, ALU_OUT=most-negative, ALU_OUT2=0, OF_OUT=1.
REQ-012 SHALL hold ALU_OUT, ALU_OUT2, OF_OUT, DZ_OUT and BF_OUT stable from completion until the next completion; all flags are updated at each completion.
REQ-013 SHALL drive Busy=1 in BUSY and FIN, and 0 in IDLE.
REQ-014 SHALL accept a new start in the cycle that mult_div_done is high, since the state is already IDLE.

Reset
REQ-015 SHALL, on RST assertion at any time, including mid-operation:
- clear every output to 0;
- force the state to IDLE;
- discard the in-flight operation with no done pulse.
REQ-016 SHALL accept its first start on the first rising CLK edge after RST deasserts.

Configuration
REQ-017 SHALL implement the divider only when macro MULT_DIV_UNIT_DIV_EN is defined.
REQ-018 SHALL, without MULT_DIV_UNIT_DIV_EN:
- treat div_start as unsupported: IDLE->FIN, completing at edge N+2 with ALU_OUT=0, ALU_OUT2=0, BF_OUT=1;
- leave multiply behaviour unchanged.

Structure
REQ-019 SHALL take from shared package mdu_pkg:
- state enum (IDLE/BUSY/FIN);
- operation encoding (MUL/DIV);
- iteration-count constant = OPERAND_WIDTH.
REQ-020 SHALL place a single restoring-divide iteration (partial remainder, divisor -> next remainder, quotient bit) in combinational sub-module mdu_div_step, instantiated only under MULT_DIV_UNIT_DIV_EN.

Verification
REQ-021 Bench SHALL cover:
- unsigned mult 0xFFFFFFFF x 0xFFFFFFFF -> ALU_OUT2=0xFFFFFFFE, ALU_OUT=0x00000001, done at edge N+33, Busy high for 33 cycles.
- signed mult -3 x 7 -> ALU_OUT2=0xFFFFFFFF, ALU_OUT=0xFFFFFFEB; signed div -7 / 2 -> ALU_OUT=0xFFFFFFFD, ALU_OUT2=0xFFFFFFFF.
- div 0x12345678 / 0 -> done at edge N+2, ALU_OUT=0xFFFFFFFF, ALU_OUT2=0x12345678, DZ_OUT=1; signed 0x80000000 / 0xFFFFFFFF -> ALU_OUT=0x80000000, ALU_OUT2=0, OF_OUT=1.
- mult_start and div_start together with 6, 3 -> multiply result 18; a second start during BUSY is ignored, with results and latency unchanged.
- RST pulse at edge N+10 of a multiply -> all outputs 0, no done pulse; a fresh start afterwards completes correctly.
- build without MULT_DIV_UNIT_DIV_EN: div_start -> BF_OUT=1, results 0, done at edge N+2.
